// File: rtl/secded_pipe_decoder_if.sv
// secded_pipe_decoder_if: input/output stream bundle of the SEC-DED decoder.
// slave is the decoder side, master the producer/consumer side.
interface secded_pipe_decoder_if #(
  parameter int DATA_W = 32,
  localparam int R = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7,
  localparam int CHK_W = R + 1
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              in_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_single;
  logic              out_double;

  modport slave (
    input  in_valid, in_data, in_chk, in_en, out_ready,
    output in_ready, out_valid, out_data, out_single, out_double
  );

  modport master (
    output in_valid, in_data, in_chk, in_en, out_ready,
    input  in_ready, out_valid, out_data, out_single, out_double
  );
endinterface

// File: rtl/secded_pipe_decoder.sv
// secded_pipe_decoder: pipelined SEC-DED decoder with saturating error counters.
// Define SECDED_SYNDROME_LOG_EN to add the last_syn/log_valid syndrome log.
module secded_pipe_decoder #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int R = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7
) (
  input  logic                 clk,
  input  logic                 rst,
  secded_pipe_decoder_if.slave bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     cnt_single,
  output logic [CNT_W-1:0]     cnt_double
`ifdef SECDED_SYNDROME_LOG_EN
  ,
  output logic [R:0]           last_syn,
  output logic                 log_valid
`endif
);

  function automatic int data_pos(input int idx);
    int pos;
    int n;
    pos = 2;
    n   = -1;
    while (n < idx) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) != 0) n = n + 1;
    end
    return pos;
  endfunction

  logic [R-1:0][DATA_W-1:0] hmask;
  logic [DATA_W-1:0]        flip;
  logic [R-1:0]             a_syn;
  logic                     a_par;
  logic [DATA_W-1:0]        b_data;
  logic [R-1:0]             b_syn;
  logic                     b_par;
  logic                     b_en;
  logic                     b_load;
  logic                     in_ready_w;
  logic                     out_free;

  logic              v2_q, v2_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic              single2_q, single2_d;
  logic              double2_q, double2_d;
  logic [CNT_W-1:0]  cnt_s_q, cnt_s_d;
  logic [CNT_W-1:0]  cnt_d_q, cnt_d_d;

  // Column masks and flip decoder come straight from the position map.
  for (genvar gj = 0; gj < DATA_W; gj++) begin : g_pos
    localparam int P = data_pos(gj);
    for (genvar gk = 0; gk < R; gk++) begin : g_bit
      assign hmask[gk][gj] = P[gk];
    end
    assign flip[gj] = (b_syn == R'(P));
  end

  always_comb begin
    a_syn = '0;
    for (int k = 0; k < R; k++)
      a_syn[k] = ^(bus.in_data & hmask[k]) ^ bus.in_chk[k];
    a_par = ^{bus.in_data, bus.in_chk};
  end

  assign out_free = !v2_q || bus.out_ready;

  if (PIPE_STAGES == 1) begin : g_one
    assign b_data     = bus.in_data;
    assign b_syn      = a_syn;
    assign b_par      = a_par;
    assign b_en       = bus.in_en;
    assign in_ready_w = !rst && out_free;
    assign b_load     = bus.in_valid && in_ready_w;
  end else begin : g_two
    logic              v1_q;
    logic [DATA_W-1:0] data1_q;
    logic [R-1:0]      syn1_q;
    logic              par1_q;
    logic              en1_q;
    logic              acc;

    assign b_load     = v1_q && out_free;
    assign in_ready_w = !rst && (!v1_q || b_load);
    assign acc        = bus.in_valid && in_ready_w;
    assign b_data     = data1_q;
    assign b_syn      = syn1_q;
    assign b_par      = par1_q;
    assign b_en       = en1_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q    <= 1'b0;
        data1_q <= '0;
        syn1_q  <= '0;
        par1_q  <= 1'b0;
        en1_q   <= 1'b0;
      end else if (acc) begin
        v1_q    <= 1'b1;
        data1_q <= bus.in_data;
        syn1_q  <= a_syn;
        par1_q  <= a_par;
        en1_q   <= bus.in_en;
      end else if (b_load) begin
        v1_q    <= 1'b0;
      end
    end
  end

  logic              hit;
  logic              c_raw, c_dbl, c_fix, c_chk;
  logic [DATA_W-1:0] dec_data;
  logic              dec_single;
  logic              dec_double;

  // Outcome classes are made disjoint so the decoder can be a unique case.
  always_comb begin
    hit        = |flip;
    c_raw      = !b_en;
    c_dbl      = b_en && !b_par;
    c_fix      = b_en && b_par && hit;
    c_chk      = b_en && b_par && $onehot0(b_syn);
    dec_data   = b_data;
    dec_single = 1'b0;
    dec_double = 1'b0;
    unique case (1'b1)
      c_raw: begin
      end
      c_dbl: dec_double = |b_syn;
      c_fix: begin
        dec_data   = b_data ^ flip;
        dec_single = 1'b1;
      end
      c_chk: dec_single = 1'b1;
      default: dec_double = 1'b1;
    endcase
  end

  always_comb begin
    v2_d      = v2_q;
    data2_d   = data2_q;
    single2_d = single2_q;
    double2_d = double2_q;
    if (b_load) begin
      v2_d      = 1'b1;
      data2_d   = dec_data;
      single2_d = dec_single;
      double2_d = dec_double;
    end else if (bus.out_ready) begin
      v2_d      = 1'b0;
    end
  end

  logic xfer;
  assign xfer = v2_q && bus.out_ready;

  always_comb begin
    cnt_s_d = cnt_s_q;
    cnt_d_d = cnt_d_q;
    if (clr_cnt) begin
      cnt_s_d = '0;
      cnt_d_d = '0;
    end else if (xfer) begin
      if (single2_q && cnt_s_q != '1) cnt_s_d = cnt_s_q + 1'b1;
      if (double2_q && cnt_d_q != '1) cnt_d_d = cnt_d_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q      <= 1'b0;
      data2_q   <= '0;
      single2_q <= 1'b0;
      double2_q <= 1'b0;
      cnt_s_q   <= '0;
      cnt_d_q   <= '0;
    end else begin
      v2_q      <= v2_d;
      data2_q   <= data2_d;
      single2_q <= single2_d;
      double2_q <= double2_d;
      cnt_s_q   <= cnt_s_d;
      cnt_d_q   <= cnt_d_d;
    end
  end

`ifdef SECDED_SYNDROME_LOG_EN
  logic [R:0] syn2_q, syn2_d;
  logic [R:0] last_q, last_d;
  logic       log_q, log_d;

  always_comb begin
    syn2_d = b_load ? {b_par, b_syn} : syn2_q;
    last_d = last_q;
    log_d  = log_q;
    if (clr_cnt) begin
      last_d = '0;
      log_d  = 1'b0;
    end else if (xfer && (single2_q || double2_q)) begin
      last_d = syn2_q;
      log_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syn2_q <= '0;
      last_q <= '0;
      log_q  <= 1'b0;
    end else begin
      syn2_q <= syn2_d;
      last_q <= last_d;
      log_q  <= log_d;
    end
  end

  assign last_syn  = last_q;
  assign log_valid = log_q;
`endif

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = v2_q;
  assign bus.out_data   = data2_q;
  assign bus.out_single = single2_q;
  assign bus.out_double = double2_q;
  assign cnt_single     = cnt_s_q;
  assign cnt_double     = cnt_d_q;

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// tb_secded_pipe_decoder: scoreboard bench for the SEC-DED decoder.
// Unit A: 2 stages, 16-bit counters. Unit B: 1 stage, 4-bit counters.
module tb_secded_pipe_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_a = 1'b0;
  logic        clr_b = 1'b0;
  logic [15:0] cnt_sa, cnt_da;
  logic [3:0]  cnt_sb, cnt_db;
`ifdef SECDED_SYNDROME_LOG_EN
  logic [6:0]  syn_a, syn_b;
  logic        lv_a, lv_b;
`endif

  int pass = 0;
  int total = 0;
  int cyc = 0;
  bit stall_a = 1'b0;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
  } res_t;

  res_t exp_a[$];
  res_t obs_a[$];
  res_t exp_b[$];
  res_t obs_b[$];
  int   cyc_a[$];
  int   cyc_b[$];

  secded_pipe_decoder_if #(.DATA_W(32)) ia ();
  secded_pipe_decoder_if #(.DATA_W(32)) ib ();

  secded_pipe_decoder #(
    .DATA_W(32), .PIPE_STAGES(2), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .bus(ia),
    .clr_cnt(clr_a),
    .cnt_single(cnt_sa), .cnt_double(cnt_da)
`ifdef SECDED_SYNDROME_LOG_EN
    , .last_syn(syn_a), .log_valid(lv_a)
`endif
  );

  secded_pipe_decoder #(
    .DATA_W(32), .PIPE_STAGES(1), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst), .bus(ib),
    .clr_cnt(clr_b),
    .cnt_single(cnt_sb), .cnt_double(cnt_db)
`ifdef SECDED_SYNDROME_LOG_EN
    , .last_syn(syn_b), .log_valid(lv_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ia.out_valid && ia.out_ready) begin
      obs_a.push_back({ia.out_data, ia.out_single, ia.out_double});
      cyc_a.push_back(cyc);
    end
    if (!rst && ib.out_valid && ib.out_ready) begin
      obs_b.push_back({ib.out_data, ib.out_single, ib.out_double});
      cyc_b.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Reference encoder: builds the codeword position by position.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  c;
    int          j;
    cw = '0;
    c  = '0;
    j  = 0;
    for (int pos = 1; pos <= 38; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[j];
        j++;
      end
    for (int k = 0; k < 6; k++)
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> k) & 1) == 1) c[k] = c[k] ^ cw[pos];
    c[6] = ^d ^ ^c[5:0];
    return c;
  endfunction

  task automatic send_a(input logic [31:0] d, input logic [6:0] c,
                        input logic en, input res_t e, output int t);
    logic acc;
    int   g;
    ia.in_valid = 1'b1;
    ia.in_data  = d;
    ia.in_chk   = c;
    ia.in_en    = en;
    exp_a.push_back(e);
    acc = 1'b0;
    g   = 0;
    t   = -1;
    while (!acc && g < 40) begin
      @(negedge clk);
      acc = ia.in_ready;
      t   = cyc;
      if (!acc) stall_a = 1'b1;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) begin
      total++;
      $display("FAIL send_a accept timeout data %h", d);
    end
  endtask

  task automatic send_b(input logic [31:0] d, input logic [6:0] c,
                        input logic en, input res_t e, output int t);
    logic acc;
    int   g;
    ib.in_valid = 1'b1;
    ib.in_data  = d;
    ib.in_chk   = c;
    ib.in_en    = en;
    exp_b.push_back(e);
    acc = 1'b0;
    g   = 0;
    t   = -1;
    while (!acc && g < 40) begin
      @(negedge clk);
      acc = ib.in_ready;
      t   = cyc;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) begin
      total++;
      $display("FAIL send_b accept timeout data %h", d);
    end
  endtask

  task automatic wait_a(output bit ok);
    int g;
    g = 0;
    while (obs_a.size() < exp_a.size() && g < 60) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    ok = (obs_a.size() >= exp_a.size());
  endtask

  task automatic wait_b(output bit ok);
    int g;
    g = 0;
    while (obs_b.size() < exp_b.size() && g < 60) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    ok = (obs_b.size() >= exp_b.size());
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (ia.in_ready !== 1'b0)
      $display("FAIL rst_ready_a got %b want 0", ia.in_ready);
    else pass++;
    total++;
    if (ib.in_ready !== 1'b0)
      $display("FAIL rst_ready_b got %b want 0", ib.in_ready);
    else pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (ia.in_ready !== 1'b1)
      $display("FAIL post_rst_ready got %b want 1", ia.in_ready);
    else pass++;
    total++;
    if ({ia.out_valid, ia.out_single, ia.out_double} !== 3'b000)
      $display("FAIL rst_flags got %b want 000",
               {ia.out_valid, ia.out_single, ia.out_double});
    else pass++;
    total++;
    if (ia.out_data !== 32'h0)
      $display("FAIL rst_data got %h want 0", ia.out_data);
    else pass++;
    total++;
    if ({cnt_sa, cnt_da} !== 32'h0)
      $display("FAIL rst_cnt got %h want 0", {cnt_sa, cnt_da});
    else pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean();
    res_t e, o;
    int   t, lat;
    bit   ok;
    send_a(32'hDEADBEEF, enc(32'hDEADBEEF), 1'b1,
           {32'hDEADBEEF, 1'b0, 1'b0}, t);
    ia.in_valid = 1'b0;
    wait_a(ok);
    total++;
    if (!ok) $display("FAIL clean_wait got %0d outputs want 1", obs_a.size());
    else pass++;
    if (ok) begin
      e   = exp_a.pop_front();
      o   = obs_a.pop_front();
      lat = cyc_a.pop_front() - t;
      total++;
      if (o !== e) $display("FAIL clean_out got %h want %h", o, e);
      else pass++;
      total++;
      if (lat !== 2) $display("FAIL clean_latency got %0d want 2", lat);
      else pass++;
    end
    total++;
    if ({cnt_sa, cnt_da} !== 32'h0)
      $display("FAIL clean_cnt got %h want 0", {cnt_sa, cnt_da});
    else pass++;
  endtask

  task automatic test_single();
    res_t e, o;
    int   t;
    bit   ok;
    send_a(32'hDEADBECF, enc(32'hDEADBEEF), 1'b1,
           {32'hDEADBEEF, 1'b1, 1'b0}, t);
    ia.in_valid = 1'b0;
    wait_a(ok);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        $display("FAIL single_out got none want %h", e);
        continue;
      end
      o = obs_a.pop_front();
      void'(cyc_a.pop_front());
      if (o !== e) $display("FAIL single_out got %h want %h", o, e);
      else pass++;
    end
    total++;
    if (cnt_sa !== 16'd1) $display("FAIL single_cnt got %0d want 1", cnt_sa);
    else pass++;
  endtask

  task automatic test_double();
    res_t e, o;
    int   t;
    bit   ok;
    send_a(32'h5EADBEEE, enc(32'hDEADBEEF), 1'b1,
           {32'h5EADBEEE, 1'b0, 1'b1}, t);
    send_a(32'h5EADBEEE, enc(32'hDEADBEEF), 1'b0,
           {32'h5EADBEEE, 1'b0, 1'b0}, t);
    ia.in_valid = 1'b0;
    wait_a(ok);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        $display("FAIL double_out got none want %h", e);
        continue;
      end
      o = obs_a.pop_front();
      void'(cyc_a.pop_front());
      if (o !== e) $display("FAIL double_out got %h want %h", o, e);
      else pass++;
    end
    total++;
    if ({cnt_sa, cnt_da} !== {16'd1, 16'd1})
      $display("FAIL double_cnt got %0d/%0d want 1/1", cnt_sa, cnt_da);
    else pass++;
  endtask

  task automatic test_chk_err();
    res_t e, o;
    int   t;
    bit   ok;
    logic [6:0] c;
    c = enc(32'hDEADBEEF);
    send_a(32'hDEADBEEF, c ^ 7'h40, 1'b1, {32'hDEADBEEF, 1'b1, 1'b0}, t);
    send_a(32'hDEADBEEF, c ^ 7'h04, 1'b1, {32'hDEADBEEF, 1'b1, 1'b0}, t);
    ia.in_valid = 1'b0;
    wait_a(ok);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        $display("FAIL chkerr_out got none want %h", e);
        continue;
      end
      o = obs_a.pop_front();
      void'(cyc_a.pop_front());
      if (o !== e) $display("FAIL chkerr_out got %h want %h", o, e);
      else pass++;
    end
    total++;
    if (cnt_sa !== 16'd3) $display("FAIL chkerr_cnt got %0d want 3", cnt_sa);
    else pass++;
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    int   t;
    bit   ok;
    stall_a = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send_a(32'(k) ^ 32'h80, enc(32'(k)), 1'b1,
                 {32'(k), 1'b1, 1'b0}, t);
        ia.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          ia.out_ready = !(i >= 2 && i <= 5);
          @(posedge clk);
          #1;
        end
        ia.out_ready = 1'b1;
      end
    join
    wait_a(ok);
    total++;
    if (stall_a !== 1'b1) $display("FAIL b2b_stall got %b want 1", stall_a);
    else pass++;
    total++;
    if (obs_a.size() !== 4)
      $display("FAIL b2b_count got %0d want 4", obs_a.size());
    else pass++;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if (obs_a.size() == 0) begin
        $display("FAIL b2b_out got none want %h", e);
        continue;
      end
      o = obs_a.pop_front();
      void'(cyc_a.pop_front());
      if (o !== e) $display("FAIL b2b_out got %h want %h", o, e);
      else pass++;
    end
    total++;
    if (cnt_sa !== 16'd7) $display("FAIL b2b_cnt got %0d want 7", cnt_sa);
    else pass++;
  endtask

  task automatic test_clear();
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    total++;
    if ({cnt_sa, cnt_da} !== 32'h0)
      $display("FAIL clear_cnt got %0d/%0d want 0/0", cnt_sa, cnt_da);
    else pass++;
  endtask

  task automatic test_midreset();
    int t;
    ia.out_ready = 1'b0;
    send_a(32'h11, enc(32'h11), 1'b1, {32'h11, 1'b0, 1'b0}, t);
    send_a(32'h22, enc(32'h22), 1'b1, {32'h22, 1'b0, 1'b0}, t);
    ia.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ia.in_ready !== 1'b0)
      $display("FAIL midrst_ready got %b want 0", ia.in_ready);
    else pass++;
    rst = 1'b0;
    ia.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (obs_a.size() !== 0)
      $display("FAIL midrst_flush got %0d outputs want 0", obs_a.size());
    else pass++;
    total++;
    if (ia.out_valid !== 1'b0)
      $display("FAIL midrst_valid got %b want 0", ia.out_valid);
    else pass++;
    exp_a.delete();
  endtask

  task automatic test_saturate();
    res_t e, o;
    int   t, t0, lat;
    bit   ok;
    logic [31:0] base;
    ib.out_ready = 1'b1;
    t0 = -1;
    for (int i = 0; i < 17; i++) begin
      base = 32'h1234_0000 + 32'(i);
      send_b(base ^ (32'h1 << (i % 32)), enc(base), 1'b1,
             {base, 1'b1, 1'b0}, t);
      if (i == 0) t0 = t;
    end
    ib.in_valid = 1'b0;
    wait_b(ok);
    if (cyc_b.size() > 0) begin
      lat = cyc_b[0] - t0;
      total++;
      if (lat !== 1) $display("FAIL sat_latency got %0d want 1", lat);
      else pass++;
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      total++;
      if (obs_b.size() == 0) begin
        $display("FAIL sat_out got none want %h", e);
        continue;
      end
      o = obs_b.pop_front();
      void'(cyc_b.pop_front());
      if (o !== e) $display("FAIL sat_out got %h want %h", o, e);
      else pass++;
    end
    total++;
    if ({cnt_sb, cnt_db} !== {4'd15, 4'd0})
      $display("FAIL sat_cnt got %0d/%0d want 15/0", cnt_sb, cnt_db);
    else pass++;

    send_b(32'hCAFE0001, enc(32'hCAFE0000), 1'b1,
           {32'hCAFE0000, 1'b1, 1'b0}, t);
    ib.in_valid = 1'b0;
    clr_b = 1'b1;
    @(negedge clk);
    total++;
    if (ib.out_valid !== 1'b1)
      $display("FAIL clr_coinc_valid got %b want 1", ib.out_valid);
    else pass++;
    @(posedge clk);
    #1 clr_b = 1'b0;
    total++;
    if (cnt_sb !== 4'd0) $display("FAIL clr_coinc_cnt got %0d want 0", cnt_sb);
    else pass++;
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      total++;
      if (obs_b.size() == 0) begin
        $display("FAIL clr_out got none want %h", e);
        continue;
      end
      o = obs_b.pop_front();
      void'(cyc_b.pop_front());
      if (o !== e) $display("FAIL clr_out got %h want %h", o, e);
      else pass++;
    end
  endtask

  initial begin
    ia.in_valid  = 1'b0;
    ia.in_data   = '0;
    ia.in_chk    = '0;
    ia.in_en     = 1'b1;
    ia.out_ready = 1'b1;
    ib.in_valid  = 1'b0;
    ib.in_data   = '0;
    ib.in_chk    = '0;
    ib.in_en     = 1'b1;
    ib.out_ready = 1'b1;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_chk_err();
    test_back_to_back();
    test_clear();
    test_midreset();
    test_saturate();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
